// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: times PWDN, RESET and XCLK bring-up in 1 us steps, then starts SCCB config.
// Optional config timeout (enters FAULT) is compiled in with `define CAM_SEQ_TIMEOUT_EN.
module cam_pwr_seq #(
    parameter int unsigned CLKDIV      = 50,
    parameter int unsigned T_PWDN_US   = 1000,
    parameter int unsigned T_RST_US    = 1000,
    parameter int unsigned T_INIT_US   = 20000,
    parameter int unsigned T_CFG_TO_US = 50000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic start,
    input  logic cfg_done,
    output logic cam_pwdn,
    output logic cam_rst_n,
    output logic xclk_en,
    output logic cfg_start,
    output logic busy,
    output logic ready,
    output logic fault
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PWDN_WAIT = 3'd1,
        S_RST_WAIT  = 3'd2,
        S_INIT_WAIT = 3'd3,
        S_CFG       = 3'd4,
        S_READY     = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    // Last us count of each timed state; a zero duration behaves as one microsecond.
    localparam logic [7:0]  PRESC_LAST = 8'(CLKDIV - 1);
    localparam logic [15:0] PWDN_LAST  = (T_PWDN_US == 0) ? 16'd0 : 16'(T_PWDN_US - 1);
    localparam logic [15:0] RST_LAST   = (T_RST_US  == 0) ? 16'd0 : 16'(T_RST_US  - 1);
    localparam logic [15:0] INIT_LAST  = (T_INIT_US == 0) ? 16'd0 : 16'(T_INIT_US - 1);
`ifdef CAM_SEQ_TIMEOUT_EN
    localparam logic [15:0] CFG_LAST   = (T_CFG_TO_US == 0) ? 16'd0 : 16'(T_CFG_TO_US - 1);
`endif

    state_t      state_reg, state_next;
    logic [7:0]  presc_reg, presc_next;
    logic [15:0] us_reg, us_next;
    logic        tick;
    logic        count_en;

    logic        cam_pwdn_next;
    logic        cam_rst_n_next;
    logic        xclk_en_next;
    logic        cfg_start_next;
    logic        busy_next;
    logic        ready_next;
    logic        fault_next;

    assign tick = (presc_reg == PRESC_LAST);

    always_comb begin
        count_en = 1'b0;
        case (state_reg)
            S_PWDN_WAIT, S_RST_WAIT, S_INIT_WAIT: count_en = 1'b1;
`ifdef CAM_SEQ_TIMEOUT_EN
            S_CFG:                                count_en = 1'b1;
`endif
            default:                              count_en = 1'b0;
        endcase
    end

    // Next-state logic; start is only honoured in the resting states.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_READY, S_FAULT: begin
                if (start)
                    state_next = S_PWDN_WAIT;
            end
            S_PWDN_WAIT: begin
                if (tick && (us_reg == PWDN_LAST))
                    state_next = S_RST_WAIT;
            end
            S_RST_WAIT: begin
                if (tick && (us_reg == RST_LAST))
                    state_next = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (tick && (us_reg == INIT_LAST))
                    state_next = S_CFG;
            end
            S_CFG: begin
                // cfg_done takes priority over a timeout landing on the same cycle
                if (cfg_done)
                    state_next = S_READY;
`ifdef CAM_SEQ_TIMEOUT_EN
                else if (tick && (us_reg == CFG_LAST))
                    state_next = S_FAULT;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Prescaler and us counter restart on every state change.
    always_comb begin
        presc_next = presc_reg;
        us_next    = us_reg;
        if ((state_next != state_reg) || !count_en) begin
            presc_next = 8'd0;
            us_next    = 16'd0;
        end else if (tick) begin
            presc_next = 8'd0;
            us_next    = us_reg + 16'd1;
        end else begin
            presc_next = presc_reg + 8'd1;
        end
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        cam_pwdn_next  = 1'b1;
        cam_rst_n_next = 1'b0;
        xclk_en_next   = 1'b0;
        busy_next      = 1'b0;
        ready_next     = 1'b0;
        fault_next     = 1'b0;
        cfg_start_next = (state_next == S_CFG) && (state_reg != S_CFG);
        case (state_next)
            S_IDLE: begin
                cam_pwdn_next  = 1'b1;
                cam_rst_n_next = 1'b0;
                xclk_en_next   = 1'b0;
            end
            S_PWDN_WAIT: begin
                cam_pwdn_next  = 1'b1;
                cam_rst_n_next = 1'b0;
                xclk_en_next   = 1'b1;
                busy_next      = 1'b1;
            end
            S_RST_WAIT: begin
                cam_pwdn_next  = 1'b0;
                cam_rst_n_next = 1'b0;
                xclk_en_next   = 1'b1;
                busy_next      = 1'b1;
            end
            S_INIT_WAIT, S_CFG: begin
                cam_pwdn_next  = 1'b0;
                cam_rst_n_next = 1'b1;
                xclk_en_next   = 1'b1;
                busy_next      = 1'b1;
            end
            S_READY: begin
                cam_pwdn_next  = 1'b0;
                cam_rst_n_next = 1'b1;
                xclk_en_next   = 1'b1;
                ready_next     = 1'b1;
            end
            S_FAULT: begin
                cam_pwdn_next  = 1'b1;
                cam_rst_n_next = 1'b0;
                xclk_en_next   = 1'b0;
`ifdef CAM_SEQ_TIMEOUT_EN
                fault_next     = 1'b1;
`endif
            end
            default: begin
                cam_pwdn_next  = 1'b1;
                cam_rst_n_next = 1'b0;
                xclk_en_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            presc_reg <= 8'd0;
            us_reg    <= 16'd0;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            xclk_en   <= 1'b0;
            cfg_start <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            us_reg    <= us_next;
            cam_pwdn  <= cam_pwdn_next;
            cam_rst_n <= cam_rst_n_next;
            xclk_en   <= xclk_en_next;
            cfg_start <= cfg_start_next;
            busy      <= busy_next;
            ready     <= ready_next;
            fault     <= fault_next;
        end
    end

endmodule
